// File: rtl/fm_modulate_pkg.sv
// Shared Q10 helpers, CORDIC constants and FSM state type for the FM modulator.
package fm_modulate_pkg;

  localparam int BITS        = 10;
  localparam int CORDIC_GAIN = 622;  // 0.607253 in Q10
  localparam logic signed [31:0] PREEMPH_COEF = 32'sd870;

  typedef enum logic [1:0] {IDLE, ROTATE, WRITE} state_t;

  function automatic logic signed [63:0] QUANTIZE(input logic signed [63:0] v);
    return v <<< BITS;
  endfunction

  function automatic logic signed [63:0] DEQUANTIZE(input logic signed [63:0] v);
    return v >>> BITS;
  endfunction

  // atan(2^-i) in phase units where 2^32 is one full turn
  function automatic logic [31:0] cordic_atan(input int i);
    case (i)
      0:       return 32'h20000000;
      1:       return 32'h12E4051E;
      2:       return 32'h09FB385B;
      3:       return 32'h051111D4;
      4:       return 32'h028B0D43;
      5:       return 32'h0145D7E1;
      6:       return 32'h00A2F61E;
      7:       return 32'h00517C55;
      8:       return 32'h0028BE53;
      9:       return 32'h00145F2F;
      10:      return 32'h000A2F98;
      11:      return 32'h000517CC;
      12:      return 32'h00028BE6;
      13:      return 32'h000145F3;
      14:      return 32'h0000A2FA;
      15:      return 32'h0000517D;
      default: return 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/fm_cordic.sv
// Iterative CORDIC rotator: quadrant pre-rotation, one load cycle, then one
// micro-rotation per cycle. done, cos_out and sin_out are valid in the last iteration cycle.
module fm_cordic
  import fm_modulate_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        phase,
  input  logic signed [31:0] x0,
  output logic signed [31:0] cos_out,
  output logic signed [31:0] sin_out,
  output logic               done
);

  localparam int CW    = 40;
  localparam int GUARD = 8;
  localparam int IW    = $clog2(ITERS);
  localparam logic signed [CW-1:0] HALF = CW'(1 << (GUARD-1));

  logic signed [CW-1:0] x, y, x_nxt, y_nxt, x_init, y_init, amp, x_rnd, y_rnd;
  logic signed [31:0]   z, z_nxt, atan_i;
  logic                 busy;
  logic [IW-1:0]        iter;

  // Guard bits below the Q10 LSB keep shift truncation from piling up.
  assign amp = {{(CW-32){x0[31]}}, x0} <<< GUARD;

  always_comb begin
    x_init = '0;
    y_init = '0;
    case (phase[31:30])
      2'd0: x_init = amp;
      2'd1: y_init = amp;
      2'd2: x_init = -amp;
      2'd3: y_init = -amp;
      default: x_init = amp;
    endcase
  end

  always_comb begin
    atan_i = $signed(cordic_atan(int'(iter)));
    if (!z[31]) begin
      x_nxt = x - (y >>> iter);
      y_nxt = y + (x >>> iter);
      z_nxt = z - atan_i;
    end else begin
      x_nxt = x + (y >>> iter);
      y_nxt = y - (x >>> iter);
      z_nxt = z + atan_i;
    end
  end

  assign done  = busy && (iter == IW'(ITERS-1));
  assign x_rnd = (x_nxt + HALF) >>> GUARD;
  assign y_rnd = (y_nxt + HALF) >>> GUARD;
  assign cos_out = x_rnd[31:0];
  assign sin_out = y_rnd[31:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start) begin
      x    <= x_init;
      y    <= y_init;
      z    <= {2'b00, phase[29:0]};
      iter <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      x <= x_nxt;
      y <= y_nxt;
      z <= z_nxt;
      if (done) busy <= 1'b0;
      else      iter <= iter + 1'b1;
    end
  end

endmodule

// File: rtl/fm_modulate.sv
// FM modulator: audio FIFO pop -> phase accumulate -> CORDIC -> I/Q FIFO push.
// Optional pre-emphasis is enabled with `define FM_MOD_PREEMPH_EN.
module fm_modulate
  import fm_modulate_pkg::*;
#(
  parameter int DEV_SCALE    = 1228800,
  parameter int AMPLITUDE    = 1024,
  parameter int CORDIC_ITERS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_fifo_empty,
  output logic        input_rd_en,
  input  logic [31:0] audio_in,
  output logic [31:0] real_out,
  output logic [31:0] imag_out,
  output logic        wr_en_out,
  input  logic        out_fifo_full
);

  localparam logic signed [31:0] DEV_S = 32'(DEV_SCALE);
  localparam logic signed [31:0] X0 =
    32'((AMPLITUDE * CORDIC_GAIN + (1 << (BITS-1))) >>> BITS);

  state_t             state;
  logic               start, pop, done;
  logic [31:0]        phase;
  logic signed [31:0] scaled, inc, cos_v, sin_v;

  assign pop         = reset && (state == IDLE) && !input_fifo_empty;
  assign input_rd_en = pop;
  assign wr_en_out   = reset && (state == WRITE) && !out_fifo_full;

`ifdef FM_MOD_PREEMPH_EN
  logic signed [31:0] x_prev;
  logic signed [63:0] emph;

  assign emph   = DEQUANTIZE(64'(x_prev) * 64'(PREEMPH_COEF));
  assign scaled = $signed(audio_in) - $signed(emph[31:0]);

  always_ff @(posedge clk) begin
    if (!reset)   x_prev <= '0;
    else if (pop) x_prev <= $signed(audio_in);
  end
`else
  assign scaled = $signed(audio_in);
`endif

  // Low 32 bits of the product are the wrapped phase step.
  assign inc = scaled * DEV_S;

  fm_cordic #(.ITERS(CORDIC_ITERS)) u_cordic (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .phase   (phase),
    .x0      (X0),
    .cos_out (cos_v),
    .sin_out (sin_v),
    .done    (done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      start    <= 1'b0;
      phase    <= '0;
      real_out <= '0;
      imag_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          start <= 1'b0;
          if (pop) begin
            phase <= phase + inc;
            start <= 1'b1;
            state <= ROTATE;
          end
        end
        ROTATE: begin
          start <= 1'b0;
          if (done) begin
            real_out <= cos_v;
            imag_out <= sin_v;
            state    <= WRITE;
          end
        end
        WRITE: begin
          start <= 1'b0;
          if (!out_fifo_full) state <= IDLE;
        end
        default: begin
          start <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_modulate.sv
// Self-checking bench for fm_modulate: trigonometric reference model with
// pop/write timing expectations, directed cases and randomized traffic.
module tb_fm_modulate;

  localparam int DEV = 1228800;
  localparam int LAT = 18;   // pop cycle to write cycle
  localparam int PER = 19;   // write spacing with a backlog
  localparam real TWO_PI = 6.283185307179586;

  logic        clk = 1'b0;
  logic        reset, input_fifo_empty, input_rd_en, wr_en_out, out_fifo_full;
  logic [31:0] audio_in, real_out, imag_out;

  always #5 clk = ~clk;

  fm_modulate dut (
    .clk              (clk),
    .reset            (reset),
    .input_fifo_empty (input_fifo_empty),
    .input_rd_en      (input_rd_en),
    .audio_in         (audio_in),
    .real_out         (real_out),
    .imag_out         (imag_out),
    .wr_en_out        (wr_en_out),
    .out_fifo_full    (out_fifo_full)
  );

  int          q[$];
  int          n_checks = 0, n_fail = 0, cyc = 0;
  bit          inflight = 0, held_exact = 1, rand_full = 0;
  int          age = 0, exp_re = 0, exp_im = 0, held_re = 0, held_im = 0;
  logic [31:0] mphase = '0;
  int          dut_writes = 0, pop_cyc = 0, last_re = 0, last_im = 0;
  int          wr_cyc[$];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_pop(input int a);
    real ang;
    mphase = mphase + 32'(a * DEV);
    ang    = real'(mphase) * TWO_PI / 4294967296.0;
    exp_re = int'($cos(ang) * 1024.0);
    exp_im = int'($sin(ang) * 1024.0);
  endtask

  task automatic cycle();
    bit exp_rd, exp_wr;
    int re, im;
    input_fifo_empty = (q.size() == 0);
    audio_in         = (q.size() != 0) ? 32'(q[0]) : $urandom;
    if (rand_full) out_fifo_full = ($urandom_range(0, 3) == 0);
    @(negedge clk);
    cyc++;
    exp_rd = reset && !inflight && (q.size() > 0);
    exp_wr = reset && inflight && (age >= LAT) && !out_fifo_full;
    re = $signed(real_out);
    im = $signed(imag_out);
    chk("rd_en", input_rd_en === exp_rd, int'(input_rd_en), int'(exp_rd));
    chk("wr_en", wr_en_out === exp_wr, int'(wr_en_out), int'(exp_wr));
    chk("rd_wr_exclusive", !(input_rd_en === 1'b1 && wr_en_out === 1'b1), int'(input_rd_en), 0);
    if (held_exact) begin
      chk("real_out", real_out === 32'(held_re), re, held_re);
      chk("imag_out", imag_out === 32'(held_im), im, held_im);
    end else begin
      chk("real_out", absd(re, held_re) <= 2, re, held_re);
      chk("imag_out", absd(im, held_im) <= 2, im, held_im);
    end
    if (wr_en_out === 1'b1) begin
      dut_writes++;
      wr_cyc.push_back(cyc);
      last_re = re;
      last_im = im;
    end
    if (input_rd_en === 1'b1) pop_cyc = cyc;
    if (!reset) begin
      inflight = 0; mphase = '0;
      held_re = 0; held_im = 0; held_exact = 1;
    end else begin
      if (inflight) begin
        if (age == LAT-1) begin
          held_re = exp_re; held_im = exp_im; held_exact = 0;
        end
        if (exp_wr) inflight = 0;
        else        age++;
      end
      if (exp_rd) begin
        model_pop(q.pop_front());
        inflight = 1;
        age = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) cycle();
    reset = 1'b1;
  endtask

  task automatic run_writes(input int n, input int budget);
    int target, k;
    target = dut_writes + n;
    k = 0;
    while (dut_writes < target && k < budget) begin
      cycle();
      k++;
    end
    chk("write_timeout", dut_writes >= target, dut_writes, target);
  endtask

  task automatic run_until_age(input int a, input int budget);
    int k;
    k = 0;
    while (!(inflight && age >= a) && k < budget) begin
      cycle();
      k++;
    end
    chk("age_timeout", inflight && age >= a, age, a);
  endtask

  initial begin
    int w0;
    reset = 1'b0;
    out_fifo_full = 1'b0;
    input_fifo_empty = 1'b1;
    audio_in = '0;
    @(posedge clk);
    #1;

    // Audio 0 waits in the FIFO during reset: no pop until reset releases.
    q.push_back(0);
    do_reset(3);
    run_writes(1, 40);
    chk("t1_pop_to_write", wr_cyc[$] - pop_cyc == LAT, wr_cyc[$] - pop_cyc, LAT);
    chk("t1_real", absd(last_re, 1024) <= 2, last_re, 1024);
    chk("t1_imag", absd(last_im, 0) <= 2, last_im, 0);

    do_reset(2);
    q.push_back(256);
    run_writes(1, 40);
    chk("t2_phase", mphase == 32'h12C00000, int'(mphase), 32'h12C00000);
    chk("t2_real", absd(last_re, 917) <= 2, last_re, 917);
    chk("t2_imag", absd(last_im, 455) <= 2, last_im, 455);

    do_reset(2);
    repeat (4) q.push_back(1024);
    run_writes(4, 120);
    chk("t3_phase", mphase == 32'd738197504, int'(mphase), 738197504);
    chk("t3_real", absd(last_re, 483) <= 2, last_re, 483);
    chk("t3_imag", absd(last_im, 903) <= 2, last_im, 903);
    chk("t3_spacing", wr_cyc[$] - wr_cyc[$-1] == PER, wr_cyc[$] - wr_cyc[$-1], PER);

    do_reset(2);
    q.push_back(-256);
    run_writes(1, 40);
    chk("t4_real", absd(last_re, 917) <= 2, last_re, 917);
    chk("t4_imag", absd(last_im, -455) <= 2, last_im, -455);

    // Backpressure in WRITE with a second sample waiting.
    do_reset(2);
    out_fifo_full = 1'b1;
    q.push_back(512);
    q.push_back(100);
    run_until_age(LAT, 40);
    w0 = dut_writes;
    repeat (10) cycle();
    chk("t5_no_write_while_full", dut_writes == w0, dut_writes, w0);
    out_fifo_full = 1'b0;
    cycle();
    chk("t5_release_write", dut_writes == w0 + 1, dut_writes, w0 + 1);
    run_writes(1, 40);

    // Reset in the middle of the rotation discards the sample.
    do_reset(2);
    q.push_back(300);
    run_until_age(9, 40);
    w0 = dut_writes;
    do_reset(1);
    repeat (30) cycle();
    chk("t6_no_write_after_reset", dut_writes == w0, dut_writes, w0);
    chk("t6_phase_cleared", mphase == 32'd0, int'(mphase), 0);
    q.push_back(0);
    run_writes(1, 40);
    chk("t6_real", absd(last_re, 1024) <= 2, last_re, 1024);
    chk("t6_imag", absd(last_im, 0) <= 2, last_im, 0);

    // Random audio with random backpressure.
    do_reset(2);
    rand_full = 1;
    for (int i = 0; i < 20; i++) q.push_back(int'($urandom_range(0, 2047)) - 1024);
    run_writes(20, 2000);
    rand_full = 0;
    out_fifo_full = 1'b0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
